// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the data memory responder and its storage array.
// The optional error feature is selected by the MEM_RESP_ERR_EN macro in data_mem_responder.
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_word_array.sv
// Word storage built from one byte-wide RAM per byte lane; synchronous byte-enabled
// write port and a registered read port. Contents are never reset.
module mem_word_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [AW-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  // Splitting by lane keeps each RAM single-writer, so partial writes infer cleanly.
  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rd_byte_d;
      logic [7:0] rd_byte_q;

      always_comb begin
        rd_byte_d = lane_mem[rd_idx];
      end

      always_ff @(posedge clk) begin
        if (wr_en && wr_be[gi]) begin
          lane_mem[wr_idx] <= wr_data[8*gi +: 8];
        end
        rd_byte_q <= rd_byte_d;
      end

      assign rd_data[8*gi +: 8] = rd_byte_q;
    end
  endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: accept, WAIT_CYCLES wait states, then a held response.
// Define MEM_RESP_ERR_EN to fault misaligned or out-of-range addresses instead of wrapping.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [AW-1:0]     req_idx;
  logic              req_fault;
  logic              accept;
  logic              mem_we;
  logic [AW-1:0]     rd_idx;
  logic [WORD_W-1:0] mem_rdata;

  assign req_idx = req_addr[2 +: AW];

`ifdef MEM_RESP_ERR_EN
  assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH_WORDS));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:2+AW]};
  assign req_fault = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Address the RAM from the live request while idle so the word is ready even with zero wait states.
  assign rd_idx = (state_q == ST_IDLE) ? req_idx : idx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = req_fault;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          if (err_q || write_q) begin
            rsp_rdata_d = '0;
            mem_we      = write_q && !err_q;
          end else begin
            rsp_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_be   (be_q),
    .rd_idx  (rd_idx),
    .rd_data (mem_rdata)
  );

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, 64, number of 32-bit words stored; power of two, 2..1024.
REQ-002 Parameter: WAIT_CYCLES, 2, wait states between request accept and response; 0..15.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  1  initiator presents a request.
REQ-006 Port: req_ready  output  1  block accepts a request this cycle.
REQ-007 Port: req_write  input  1  1 = store, 0 = load.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  store data.
REQ-010 Port: req_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 Port: rsp_valid  output  1  response available.
REQ-012 Port: rsp_ready  input  1  initiator consumes the response.
REQ-013 Port: rsp_rdata  output  32  load data; 0 for stores.
REQ-014 Port: rsp_err  output  1  request faulted (see Configuration).

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE, and only while reset is low.
REQ-016 Accept = req_valid & req_ready; on accept, write, addr, wdata and be SHALL be latched and the FSM SHALL enter WAIT with the counter loaded to WAIT_CYCLES.
REQ-017 WAIT SHALL decrement the counter each cycle and enter RESP when it reaches 0; with WAIT_CYCLES=0, accept SHALL go through WAIT for one cycle. rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-018 Word index SHALL be addr[2 +: log2(DEPTH_WORDS)]; higher address bits SHALL be ignored (wrap) when errors are disabled.
REQ-019 A store SHALL commit on the WAIT->RESP edge, updating only the bytes whose be bit is 1; be=0000 SHALL leave memory unchanged and still respond.
REQ-020 A load SHALL capture the word into rsp_rdata on the WAIT->RESP edge.
REQ-021 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL hold stable until rsp_ready=1; RESP->IDLE on rsp_ready, with rsp_valid falling on the same edge.
REQ-022 No new request SHALL be accepted before the current response is consumed; there is at most one outstanding transaction.
REQ-023 req_* inputs SHALL be ignored outside the accept cycle.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and req_ready=0.
REQ-025 A reset in WAIT SHALL drop the pending transaction, and an uncommitted store SHALL NOT be written; a reset in RESP SHALL drop the response.
REQ-026 Storage contents SHALL NOT be reset.

Configuration
REQ-027 Macro MEM_RESP_ERR_EN: when defined, a request with addr[1:0]!=0 or addr>=4*DEPTH_WORDS SHALL NOT access storage and SHALL respond with rsp_err=1 and rsp_rdata=0 at the normal latency.
REQ-028 Without MEM_RESP_ERR_EN, rsp_err SHALL be constant 0, addr[1:0] SHALL be ignored, and REQ-018 wrap SHALL apply.

Structure
REQ-029 Shared package mips_mem_pkg SHALL hold the FSM state type, WORD_W=32, BE_W=4 and the wait-counter width.
REQ-030 Storage SHALL be a sub-module mem_word_array with one synchronous byte-enabled write port and one read port; the FSM, counter and response registers SHALL live in data_mem_responder.

Verification
REQ-031 Store addr=0x10, wdata=0xDEADBEEF, be=1111; then load 0x10 -> rsp_rdata=0xDEADBEEF, with rsp_valid rising 3 cycles after each accept (WAIT_CYCLES=2).
REQ-032 Store 0x10, wdata=0x11223344, be=0101, over 0xDEADBEEF; then load -> 0xDE22BE44.
REQ-033 Hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, and req_valid=1 not accepted.
REQ-034 Assert reset in WAIT of a store to 0x20 (prior value 0x0) -> rsp_valid=0 immediately; a load of 0x20 after reset returns 0x0.
REQ-035 With MEM_RESP_ERR_EN, load 0x102 (DEPTH_WORDS=64) -> rsp_err=1, rsp_rdata=0; without the macro, store 0x100 aliases word 0, so a load of 0x0 returns the stored data.
REQ-036 With WAIT_CYCLES=0, back-to-back loads with rsp_ready=1 -> one accept every 3 cycles, latency 1.
